// File: rtl/sort_vis_pkg.sv
// Shared definitions for the bar-sort visualiser: FSM encoding, button
// arbitration and the default timing constants used by the engine and top level.
package sort_vis_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int unsigned STEP_PERIOD_DEF     = 100_000_000;
   localparam int unsigned CNT_W_DEF           = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      BTN_NONE,
      BTN_PAUSE,
      BTN_NEXT,
      BTN_PREV
   } btn_sel_t;

   // Simultaneous presses resolve to a single winner: pause > next > prev.
   function automatic btn_sel_t btn_winner(input logic pause_p,
                                           input logic next_p,
                                           input logic prev_p);
      if (pause_p) begin
         return BTN_PAUSE;
      end else if (next_p) begin
         return BTN_NEXT;
      end else if (prev_p) begin
         return BTN_PREV;
      end
      return BTN_NONE;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: 2-flop synchroniser, stability counter and a
// single-cycle press pulse on each accepted 0->1 transition.
module btn_debounce
   import sort_vis_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic level_o,
   output logic press_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            press_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would chain the synchroniser into one flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule

// File: rtl/sort_step_ctrl.sv
// Run/pause/single-step controller for the sort visualiser: conditions the
// three buttons and emits registered one-cycle step_fwd / step_back strobes.
module sort_step_ctrl
   import sort_vis_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned STEP_PERIOD     = STEP_PERIOD_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       btn_pause,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       sort_done,
   output logic       step_fwd,
   output logic       step_back,
   output logic       paused,
   output logic [1:0] state
);

   localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(STEP_PERIOD - 1);

   logic [2:0]       unused_levels;
   logic             press_pause, press_next, press_prev;
   btn_sel_t         winner;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             fwd_q, fwd_d;
   logic             back_q, back_d;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_pause (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (btn_pause),
      .level_o (unused_levels[0]),
      .press_o (press_pause)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_next (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (btn_next),
      .level_o (unused_levels[1]),
      .press_o (press_next)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_prev (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (btn_prev),
      .level_o (unused_levels[2]),
      .press_o (press_prev)
   );

   assign winner = btn_winner(press_pause, press_next, press_prev);

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      fwd_d   = 1'b0;
      back_d  = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         timer_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               timer_d = '0;
               state_d = sort_done ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
               if (sort_done) begin
                  state_d = ST_DONE;
                  timer_d = '0;
               end else if (winner == BTN_PAUSE) begin
                  state_d = ST_PAUSE;
                  timer_d = '0;
               end else if (timer_q == TIMER_LAST) begin
                  fwd_d   = 1'b1;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            ST_PAUSE: begin
               timer_d = '0;
               if (sort_done) begin
                  state_d = ST_DONE;
               end else begin
                  unique case (winner)
                     BTN_PAUSE: state_d = ST_RUN;
                     BTN_NEXT:  fwd_d   = 1'b1;
                     BTN_PREV:  back_d  = 1'b1;
                     default:   ;
                  endcase
               end
            end
            ST_DONE: begin
               // Only an undo leaves DONE; a winning pause/next press is dropped.
               timer_d = '0;
               if (winner == BTN_PREV) begin
                  back_d  = 1'b1;
                  state_d = ST_PAUSE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               timer_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         fwd_q   <= 1'b0;
         back_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         fwd_q   <= fwd_d;
         back_q  <= back_d;
      end
   end

   assign step_fwd  = fwd_q;
   assign step_back = back_q;
   assign paused    = (state_q == ST_PAUSE);
   assign state     = state_q;

endmodule

// File: tb/tb_sort_step_ctrl.sv
// Bench for sort_step_ctrl: directed scenarios with literal expectations plus
// randomized button traffic compared every cycle against a behavioural model.
module tb_sort_step_ctrl;

   localparam int D = 4;
   localparam int P = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       b_pause, b_next, b_prev;
   logic       sd;
   logic       step_fwd, step_back, paused;
   logic [1:0] state;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sort_step_ctrl #(.DEBOUNCE_CYCLES(D), .STEP_PERIOD(P), .CNT_W(32)) dut (
      .clk       (clk),
      .reset     (rst),
      .enable    (en),
      .btn_pause (b_pause),
      .btn_next  (b_next),
      .btn_prev  (b_prev),
      .sort_done (sd),
      .step_fwd  (step_fwd),
      .step_back (step_back),
      .paused    (paused),
      .state     (state)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a button level flips once the synchronised raw input
   // has disagreed with it for D consecutive samples (raw seen 2 edges late).
   // Auto-steps fire every P edges measured from the edge RUN was entered.
   logic [D:0] hist [3];
   logic       lvl [3];
   logic       press_m [3];
   int         m_state;
   bit         m_fwd, m_back;
   longint     edge_n, run_entry;

   always @(posedge clk) begin
      logic [2:0] raw;
      logic       flip;
      int         win;
      raw = {b_prev, b_next, b_pause};
      if (rst) begin
         for (int b = 0; b < 3; b++) begin
            hist[b]    = '0;
            lvl[b]     = 1'b0;
            press_m[b] = 1'b0;
         end
         m_state   = 0;
         m_fwd     = 0;
         m_back    = 0;
         edge_n    = 0;
         run_entry = 0;
      end else begin
         edge_n++;
         m_fwd  = 0;
         m_back = 0;
         win = press_m[0] ? 0 : press_m[1] ? 1 : press_m[2] ? 2 : -1;
         if (!en) begin
            m_state = 0;
         end else begin
            case (m_state)
               0: begin
                  m_state   = sd ? 3 : 1;
                  run_entry = edge_n;
               end
               1: begin
                  if (sd) m_state = 3;
                  else if (win == 0) m_state = 2;
                  else if (((edge_n - run_entry) % P) == 0) m_fwd = 1;
               end
               2: begin
                  if (sd) m_state = 3;
                  else if (win == 0) begin
                     m_state   = 1;
                     run_entry = edge_n;
                  end
                  else if (win == 1) m_fwd = 1;
                  else if (win == 2) m_back = 1;
               end
               default: begin
                  if (win == 2) begin
                     m_back  = 1;
                     m_state = 2;
                  end
               end
            endcase
         end
         for (int b = 0; b < 3; b++) begin
            flip = 1'b1;
            for (int j = 1; j <= D; j++)
               if (hist[b][j] == lvl[b]) flip = 1'b0;
            press_m[b] = flip && !lvl[b];
            if (flip) lvl[b] = ~lvl[b];
            hist[b] = {hist[b][D-1:0], raw[b]};
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("step_fwd", step_fwd, m_fwd);
         check("step_back", step_back, m_back);
         check("paused", paused, (m_state == 2));
         check("state", state, m_state);
         check("strobe_exclusive", step_fwd & step_back, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fwd(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!step_fwd && n < limit);
   endtask

   task automatic count_strobes(input int cycles, output int nf, output int nb);
      nf = 0;
      nb = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         nf += int'(step_fwd);
         nb += int'(step_back);
      end
   endtask

   initial begin
      int n, nf, nb, nf2, nb2;
      logic [2:0] mask;
      rst = 1'b1; en = 1'b0; sd = 1'b0;
      b_pause = 1'b0; b_next = 1'b0; b_prev = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", state, 0);
      check("reset_fwd", step_fwd, 0);
      check("reset_back", step_back, 0);
      check("reset_paused", paused, 0);
      rst = 1'b0;
      tick();
      check("idle_without_enable", state, 0);

      en = 1'b1;
      tick();
      check("enter_run", state, 1);
      wait_fwd(20, n);
      check("first_auto_step", n, 10);
      tick();
      check("auto_step_width", step_fwd, 0);
      wait_fwd(20, n);
      check("auto_step_period", n + 1, 10);

      b_pause = 1'b1;
      repeat (3) tick();
      b_pause = 1'b0;
      repeat (12) tick();
      check("glitch_ignored", state, 1);

      b_pause = 1'b1;
      repeat (6) tick();
      check("pause_not_yet", state, 1);
      tick();
      check("pause_at_t7", state, 2);
      check("paused_flag", paused, 1);
      repeat (20) tick();
      b_pause = 1'b0;
      repeat (10) tick();
      check("stay_paused_after_release", state, 2);

      b_next = 1'b1;
      count_strobes(20, nf, nb);
      b_next = 1'b0;
      count_strobes(10, nf2, nb2);
      check("next_one_fwd", nf + nf2, 1);
      check("next_no_back", nb + nb2, 0);

      b_prev = 1'b1;
      count_strobes(20, nf, nb);
      b_prev = 1'b0;
      count_strobes(10, nf2, nb2);
      check("prev_one_back", nb + nb2, 1);
      check("prev_no_fwd", nf + nf2, 0);

      b_pause = 1'b1;
      b_next  = 1'b1;
      repeat (6) tick();
      check("simul_not_yet", state, 2);
      tick();
      check("simul_pause_wins", state, 1);
      check("simul_no_fwd", step_fwd, 0);
      b_pause = 1'b0;
      b_next  = 1'b0;
      wait_fwd(20, n);
      check("resume_first_step", n, 10);

      repeat (9) tick();
      sd = 1'b1;
      tick();
      check("done_suppresses_step", step_fwd, 0);
      check("done_state", state, 3);
      sd = 1'b0;
      repeat (3) tick();
      check("done_holds", state, 3);

      b_prev = 1'b1;
      repeat (7) tick();
      check("done_prev_back", step_back, 1);
      check("done_prev_to_pause", state, 2);
      b_prev = 1'b0;
      count_strobes(20, nf, nb);
      check("done_prev_single", nf + nb, 0);

      b_pause = 1'b1;
      repeat (7) tick();
      check("pause_to_run", state, 1);
      b_pause = 1'b0;
      repeat (4) tick();
      en = 1'b0;
      tick();
      check("disable_idle", state, 0);
      check("disable_no_fwd", step_fwd, 0);
      check("disable_no_back", step_back, 0);
      repeat (10) tick();

      en = 1'b1;
      repeat (5) tick();
      check("run_before_reset", state, 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_reset_state", state, 0);
      check("async_reset_fwd", step_fwd, 0);
      check("async_reset_back", step_back, 0);
      check("async_reset_paused", paused, 0);
      en = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      tick();
      check("idle_after_reset", state, 0);
      en = 1'b1;
      tick();
      check("run_after_reset", state, 1);
      wait_fwd(20, n);
      check("timer_cleared_by_reset", n, 10);

      for (int it = 0; it < 300; it++) begin
         en = ($urandom_range(0, 24) != 0);
         sd = ($urandom_range(0, 9) == 0);
         mask = 3'($urandom_range(1, 7));
         if ($urandom_range(0, 3) != 0) mask = 3'(1 << $urandom_range(0, 2));
         {b_prev, b_next, b_pause} = mask;
         repeat ($urandom_range(1, 10)) tick();
         {b_prev, b_next, b_pause} = 3'b000;
         repeat ($urandom_range(2, 12)) tick();
         sd = 1'b0;
         repeat ($urandom_range(0, 14)) tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sort_step_ctrl.md
Name: sort_step_ctrl

Overview:
- Upstream control stage for the bar-sort visualiser.
- Conditions the three Basys3 push buttons and owns the run/pause/single-step policy.
- Emits single-cycle step_fwd / step_back strobes that advance or rewind the sort engine by one compare/swap step.
- Replaces the fixed free-running delay counter with a timed auto-step in RUN and manual stepping in PAUSE.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synced samples required to accept a button level change (10 ms at 100 MHz).
- STEP_PERIOD, 100_000_000: clk cycles between auto-steps in RUN (1 s at 100 MHz); must be >= 2.
- CNT_W, 32: width of the debounce and step timers; must hold max(DEBOUNCE_CYCLES, STEP_PERIOD).

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  sort armed (sw0 && sw1 level); low forces IDLE.
- btn_pause  in  1  raw btnC, asynchronous, bouncy.
- btn_next  in  1  raw btnR.
- btn_prev  in  1  raw btnL.
- sort_done  in  1  level from sort engine: array fully sorted.
- step_fwd  out  1  one-cycle strobe: perform next sort step.
- step_back  out  1  one-cycle strobe: undo last sort step.
- paused  out  1  high in PAUSE state.
- state  out  2  current FSM state encoding.

Behaviour:
- Reset values: step_fwd=0, step_back=0, paused=0, state=IDLE. Step timer=0. All debounced levels=0, synchronisers=0.
- Button path, per button:
  - 2-flop synchroniser.
  - Counter runs while synced level != debounced level and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the level still differing, the debounced level takes the synced value on the next edge.
  - A press pulse is asserted for exactly one cycle on the debounced 0->1 transition. Releases generate nothing.
- Latency: from a raw rise held clean, the registered step strobe appears DEBOUNCE_CYCLES+3 cycles later.
- FSM states: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- IDLE: outputs 0, timer held at 0.
  - enable=1 and sort_done=0 -> RUN.
  - enable=1 and sort_done=1 -> DONE.
- RUN:
  - Timer counts 0..STEP_PERIOD-1. At terminal count, step_fwd=1 for one cycle and the timer wraps to 0.
  - pause press -> PAUSE, timer cleared, no step that cycle even at terminal count.
  - next/prev presses ignored.
- PAUSE: paused=1, timer held at 0.
  - next press -> step_fwd one cycle.
  - prev press -> step_back one cycle.
  - pause press -> RUN with timer starting at 0, so the first auto-step comes STEP_PERIOD cycles later.
- DONE: no step_fwd, pause and next ignored.
  - prev press -> step_back one cycle and go to PAUSE.
- sort_done=1 in RUN or PAUSE -> DONE on the next edge. A step_fwd due that cycle is suppressed.
- enable=0 in any state -> IDLE on the next edge. Strobes are forced 0 that cycle and the timer is cleared. Debouncers keep running, so a held button does not retrigger.
- Simultaneous presses in the same cycle: priority pause > next > prev. Only the winner acts.
- step_fwd and step_back are never high in the same cycle. Each strobe is high for at most 1 consecutive cycle per press.
- Reset asserted mid-operation clears everything immediately (asynchronous). After deassertion, the FSM starts from IDLE on the next edge.
- Width rules: timers are unsigned CNT_W and never exceed their parameter minus 1. No wrap-around beyond the terminal value.

Decomposition:
- Shared package sort_vis_pkg holds:
  - State encoding constants (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE).
  - Default DEBOUNCE_CYCLES and STEP_PERIOD, reused by the sort engine and the top level.
- One natural sub-module, btn_debounce, instantiated 3x:
  - Parameters: DEBOUNCE_CYCLES, CNT_W.
  - Ports: clk, reset, raw in, level out, press out.
- The FSM and step timer live in sort_step_ctrl.

Test Plan:
The bench uses DEBOUNCE_CYCLES=4 and STEP_PERIOD=10.
- Reset, then enable=1, sort_done=0, no buttons -> state=RUN, and step_fwd pulses exactly every 10 cycles, each pulse 1 cycle wide.
- Glitch btn_pause high for 3 cycles, then release -> no state change. Hold it high from cycle t -> state=PAUSE and paused=1, with the press registered at t+7.
- In PAUSE, press btn_next then btn_prev (each held 20 cycles) -> exactly one step_fwd, then exactly one step_back. Holding longer produces no further strobes.
- Press pause and next in the same cycle while in PAUSE -> state=RUN, no step_fwd that cycle, and the next step_fwd comes 10 cycles later.
- In RUN, assert sort_done on the cycle the timer hits 9 -> no step_fwd and state=DONE. A subsequent prev press -> one step_back and state=PAUSE.
- In RUN, drop enable -> state=IDLE, strobes 0. Assert reset mid-count -> all outputs 0 immediately, and after release state=IDLE with timer 0.
